// File: rtl/ftdi_ft245_responder.sv
// Device-side FT245 async FIFO model: answers RD#/WR# strobes from an FTDI master
// and bridges the bytes to a host-side stream through two first-word-fall-through FIFOs.
module ftdi_ft245_fifo #(
    parameter int unsigned pDepth = 16,
    localparam int unsigned AW = $clog2(pDepth),
    localparam int unsigned CW = AW + 1
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iPush,
    input  logic [7:0]    iData,
    input  logic          iPop,
    output logic [7:0]    oData,
    output logic [CW-1:0] oCount,
    output logic          oFull,
    output logic          oEmpty
);
    logic [7:0]    mem_q [pDepth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign oFull  = (count_q == CW'(pDepth));
    assign oEmpty = (count_q == '0);
    assign oCount = count_q;
    assign oData  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = iPush && !oFull;
        pop_ok   = iPop && !oEmpty;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (push_ok) mem_q[wr_ptr_q] <= iData;
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module ftdi_ft245_responder #(
    parameter int unsigned pDepth    = 16,
    parameter int unsigned pRdDelay  = 1,
    parameter int unsigned pRecovery = 2,
    localparam int unsigned CW = $clog2(pDepth) + 1
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iRd_n,
    input  logic          iWr_n,
    input  logic [7:0]    iFifoData,
    output logic [7:0]    oFifoData,
    output logic          oFifoOe,
    output logic          oRxF_n,
    output logic          oTxE_n,
    input  logic [7:0]    iHostTxData,
    input  logic          iHostTxValid,
    output logic          oHostTxReady,
    output logic [7:0]    oHostRxData,
    output logic          oHostRxValid,
    input  logic          iHostRxReady,
    output logic [CW-1:0] oRxCount,
    output logic [CW-1:0] oTxCount,
    output logic          oErr
);
    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DRIVE = 2'd2, R_RECOV = 2'd3;
    localparam logic [1:0] W_IDLE = 2'd0, W_ACTIVE = 2'd1, W_RECOV = 2'd2;

    logic       rd_s1_q, rd_s2_q, rd_s3_q;
    logic       wr_s1_q, wr_s2_q, wr_s3_q;
    logic [7:0] data_s1_q, data_s2_q;
    logic [1:0] rd_state_q, rd_state_d, wr_state_q, wr_state_d;
    logic [7:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [7:0] fifo_data_q, fifo_data_d;
    logic       fifo_oe_q, fifo_oe_d, rxf_n_q, rxf_n_d, txe_n_q, txe_n_d, err_q, err_d;
    logic       rd_fall, rd_rise, wr_fall, wr_rise, rd_pop, wr_push;
    logic       rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0] rx_head;

    ftdi_ft245_fifo #(.pDepth(pDepth)) u_rx_fifo (
        .iClk(iClk), .iRst(iRst), .iPush(iHostTxValid), .iData(iHostTxData),
        .iPop(rd_pop), .oData(rx_head), .oCount(oRxCount), .oFull(rx_full), .oEmpty(rx_empty)
    );

    ftdi_ft245_fifo #(.pDepth(pDepth)) u_tx_fifo (
        .iClk(iClk), .iRst(iRst), .iPush(wr_push), .iData(data_s2_q),
        .iPop(iHostRxReady), .oData(oHostRxData), .oCount(oTxCount), .oFull(tx_full), .oEmpty(tx_empty)
    );

    assign oHostTxReady = !rx_full;
    assign oHostRxValid = !tx_empty;
    assign oFifoData    = fifo_data_q;
    assign oFifoOe      = fifo_oe_q;
    assign oRxF_n       = rxf_n_q;
    assign oTxE_n       = txe_n_q;
    assign oErr         = err_q;

    // Edges are taken between the second sync stage and its delayed copy.
    assign rd_fall = rd_s3_q && !rd_s2_q;
    assign rd_rise = !rd_s3_q && rd_s2_q;
    assign wr_fall = wr_s3_q && !wr_s2_q;
    assign wr_rise = !wr_s3_q && wr_s2_q;

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        fifo_data_d = fifo_data_q;
        fifo_oe_d   = fifo_oe_q;
        err_d       = err_q;
        rd_pop      = 1'b0;
        case (rd_state_q)
            R_IDLE: if (rd_fall) begin
                rd_state_d = R_WAIT;
                rd_cnt_d   = '0;
                if (rx_empty) begin
                    err_d       = 1'b1;
                    fifo_data_d = 8'h00;
                end else begin
                    fifo_data_d = rx_head;
                    rd_pop      = 1'b1;
                end
            end
            R_WAIT: if (rd_rise) begin
                rd_state_d = R_RECOV;
                rd_cnt_d   = '0;
            end else if (32'(rd_cnt_q) + 32'd1 >= pRdDelay) begin
                fifo_oe_d  = 1'b1;
                rd_state_d = R_DRIVE;
            end else begin
                rd_cnt_d = rd_cnt_q + 8'd1;
            end
            R_DRIVE: if (rd_rise) begin
                fifo_oe_d  = 1'b0;
                rd_state_d = R_RECOV;
                rd_cnt_d   = '0;
            end
            default: if (32'(rd_cnt_q) + 32'd1 >= pRecovery) rd_state_d = R_IDLE;
                     else rd_cnt_d = rd_cnt_q + 8'd1;
        endcase

        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_push    = 1'b0;
        case (wr_state_q)
            W_IDLE: if (wr_fall) begin
                wr_state_d = W_ACTIVE;
                if (tx_full) err_d = 1'b1;
                else wr_push = 1'b1;
            end
            W_ACTIVE: if (wr_rise) begin
                wr_state_d = W_RECOV;
                wr_cnt_d   = '0;
            end
            default: if (32'(wr_cnt_q) + 32'd1 >= pRecovery) wr_state_d = W_IDLE;
                     else wr_cnt_d = wr_cnt_q + 8'd1;
        endcase

        rxf_n_d = rx_empty || (rd_state_q != R_IDLE);
        txe_n_d = tx_full || (wr_state_q != W_IDLE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            {rd_s1_q, rd_s2_q, rd_s3_q} <= 3'b111;
            {wr_s1_q, wr_s2_q, wr_s3_q} <= 3'b111;
            data_s1_q   <= 8'hFF;
            data_s2_q   <= 8'hFF;
            rd_state_q  <= R_IDLE;
            wr_state_q  <= W_IDLE;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            fifo_data_q <= 8'h00;
            fifo_oe_q   <= 1'b0;
            rxf_n_q     <= 1'b1;
            txe_n_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            {rd_s1_q, rd_s2_q, rd_s3_q} <= {iRd_n, rd_s1_q, rd_s2_q};
            {wr_s1_q, wr_s2_q, wr_s3_q} <= {iWr_n, wr_s1_q, wr_s2_q};
            data_s1_q   <= iFifoData;
            data_s2_q   <= data_s1_q;
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_oe_q   <= fifo_oe_d;
            rxf_n_q     <= rxf_n_d;
            txe_n_q     <= txe_n_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_ftdi_ft245_responder.sv
// Directed bench for ftdi_ft245_responder: scoreboard queues hold the bytes each side
// should see, and every comparison is an immediate assertion.
module tb_ftdi_ft245_responder;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned RECOV = 2;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          iClk = 1'b0, iRst = 1'b1, iRd_n = 1'b1, iWr_n = 1'b1;
    logic [7:0]    iFifoData = 8'h00, iHostTxData = 8'h00;
    logic          iHostTxValid = 1'b0, iHostRxReady = 1'b0;
    logic [7:0]    oFifoData, oHostRxData;
    logic          oFifoOe, oRxF_n, oTxE_n, oHostTxReady, oHostRxValid, oErr;
    logic [CW-1:0] oRxCount, oTxCount;

    int checks = 0, failures = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    ftdi_ft245_responder #(.pDepth(DEPTH), .pRdDelay(1), .pRecovery(RECOV)) dut (
        .iClk(iClk), .iRst(iRst), .iRd_n(iRd_n), .iWr_n(iWr_n), .iFifoData(iFifoData),
        .oFifoData(oFifoData), .oFifoOe(oFifoOe), .oRxF_n(oRxF_n), .oTxE_n(oTxE_n),
        .iHostTxData(iHostTxData), .iHostTxValid(iHostTxValid), .oHostTxReady(oHostTxReady),
        .oHostRxData(oHostRxData), .oHostRxValid(oHostRxValid), .iHostRxReady(iHostRxReady),
        .oRxCount(oRxCount), .oTxCount(oTxCount), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_push(input logic [7:0] b);
        chk("host_tx_ready", oHostTxReady, 1);
        iHostTxData  = b;
        iHostTxValid = 1'b1;
        tick();
        iHostTxValid = 1'b0;
        rx_q.push_back(b);
        $display("host push %02h", b);
    endtask

    // RD# low for 'hold' clocks; the fall is detected on the 3rd edge, Oe rises one edge later.
    task automatic master_read(input int hold, input logic from_empty);
        logic [7:0] exp;
        iRd_n = 1'b0;
        repeat (4) tick();
        exp = (from_empty || rx_q.size() == 0) ? 8'h00 : rx_q.pop_front();
        chk("rd_oe_on", oFifoOe, 1);
        chk("rd_data", oFifoData, exp);
        chk("rd_rxf_busy", oRxF_n, 1);
        repeat (hold - 4) tick();
        iRd_n = 1'b1;
        repeat (2) tick();
        chk("rd_oe_held", oFifoOe, 1);
        tick();
        chk("rd_oe_off", oFifoOe, 0);
        repeat (RECOV + 2) tick();
        $display("master read %02h oe_data=%02h", exp, oFifoData);
    endtask

    task automatic master_write(input logic [7:0] b, input logic drop, input logic full_after);
        iFifoData = b;
        iWr_n = 1'b0;
        repeat (4) tick();
        iWr_n = 1'b1;
        repeat (3) tick();
        chk("wr_txe_recov", oTxE_n, 1);
        if (!drop) tx_q.push_back(b);
        for (int i = 0; i < int'(RECOV) + 1 && oTxE_n; i++) tick();
        chk("wr_txe_after", oTxE_n, full_after ? 1 : 0);
        $display("master write %02h drop=%0d txcount=%0d", b, drop, oTxCount);
    endtask

    task automatic host_drain();
        iHostRxReady = 1'b1;
        for (int i = 0; i < 3 * int'(DEPTH) && tx_q.size() > 0; i++) begin
            if (oHostRxValid) begin
                chk("host_rx_data", oHostRxData, tx_q.pop_front());
                $display("host pop %02h", oHostRxData);
            end
            tick();
        end
        iHostRxReady = 1'b0;
        chk("host_rx_left", tx_q.size(), 0);
        chk("host_rx_count0", oTxCount, 0);
    endtask

    initial begin
        // 1: reset state
        repeat (3) tick();
        iRst = 1'b0;
        tick();
        chk("rst_rxf", oRxF_n, 1);
        chk("rst_txe", oTxE_n, 0);
        chk("rst_oe", oFifoOe, 0);
        chk("rst_data", oFifoData, 0);
        chk("rst_rxcnt", oRxCount, 0);
        chk("rst_txcnt", oTxCount, 0);
        chk("rst_err", oErr, 0);

        // 2: host push then master read
        host_push(8'hA5);
        chk("push_rxf_lag", oRxF_n, 1);
        tick();
        chk("push_rxf_ready", oRxF_n, 0);
        chk("push_rxcnt", oRxCount, 1);
        master_read(6, 1'b0);
        chk("rd_rxcnt0", oRxCount, 0);
        chk("rd_rxf_empty", oRxF_n, 1);
        chk("rd_err0", oErr, 0);

        // 3: single master write
        master_write(8'h3C, 1'b0, 1'b0);
        chk("wr_valid", oHostRxValid, 1);
        chk("wr_head", oHostRxData, 8'h3C);
        chk("wr_txcnt", oTxCount, 1);
        host_drain();

        // 4: fill the TX FIFO across the pointer wrap, then overflow
        for (int i = 0; i < int'(DEPTH); i++)
            master_write(8'h10 + 8'(i * 7), 1'b0, i == int'(DEPTH) - 1);
        chk("full_txcnt", oTxCount, DEPTH);
        chk("full_txe", oTxE_n, 1);
        chk("full_err0", oErr, 0);
        master_write(8'hEE, 1'b1, 1'b1);
        chk("ovf_err", oErr, 1);
        chk("ovf_txcnt", oTxCount, DEPTH);
        host_drain();

        // 5: read while RX FIFO empty
        iRst = 1'b1;
        repeat (2) tick();
        iRst = 1'b0;
        tick();
        chk("rst2_err", oErr, 0);
        master_read(6, 1'b1);
        chk("empty_rd_err", oErr, 1);
        chk("empty_rd_rxcnt", oRxCount, 0);

        // 6: reset in the middle of a read and a write
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        tick();
        host_push(8'h5A);
        repeat (2) tick();
        iFifoData = 8'hC3;
        iRd_n = 1'b0;
        iWr_n = 1'b0;
        repeat (4) tick();
        chk("mid_oe", oFifoOe, 1);
        chk("mid_data", oFifoData, 8'h5A);
        chk("mid_txcnt", oTxCount, 1);
        iRst = 1'b1;
        tick();
        chk("mid_rst_oe", oFifoOe, 0);
        chk("mid_rst_rxcnt", oRxCount, 0);
        chk("mid_rst_txcnt", oTxCount, 0);
        chk("mid_rst_txe", oTxE_n, 0);
        chk("mid_rst_rxf", oRxF_n, 1);
        iRd_n = 1'b1;
        iWr_n = 1'b1;
        repeat (3) tick();
        iRst = 1'b0;
        rx_q.delete();
        tx_q.delete();
        tick();
        host_push(8'h77);
        tick();
        master_read(6, 1'b0);
        master_write(8'h99, 1'b0, 1'b0);
        chk("post_valid", oHostRxValid, 1);
        host_drain();
        chk("post_err", oErr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
